// File: rtl/vector_mem_access_unit.sv
// vector_mem_access_unit: memory-stage controller that runs vector loads and stores against a
// data memory with a 1-cycle registered read, doing read-modify-write for lane-masked stores.
//   clk, rst (sync, active-low)
//   req_*  : valid/ready request from execute (is_store, addr, wdata, lane_mask, tag)
//   resp_* : valid/ready response to writeback (rdata, tag, is_store, err)
//   mem_*  : data memory port (we, addr, wdata out; rdata in, valid the cycle after a read)
module vector_mem_access_unit #(
    parameter int dataSize       = 32,
    parameter int addressingSize = 32,
    parameter int vecSize        = 4,
    parameter int tagSize        = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_is_store,
    input  logic [addressingSize-1:0]     req_addr,
    input  logic [vecSize*dataSize-1:0]   req_wdata,
    input  logic [vecSize-1:0]            req_lane_mask,
    input  logic [tagSize-1:0]            req_tag,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [vecSize*dataSize-1:0]   resp_rdata,
    output logic [tagSize-1:0]            resp_tag,
    output logic                          resp_is_store,
    output logic                          resp_err,
    output logic                          mem_we,
    output logic [addressingSize-1:0]     mem_addr,
    output logic [vecSize*dataSize-1:0]   mem_wdata,
    input  logic [vecSize*dataSize-1:0]   mem_rdata
);
    typedef enum logic [2:0] {IDLE, ISSUE, CAPT, WRITE, RESP} state_t;
    state_t state, nxt;
    logic [addressingSize-1:0]   addr_q;
    logic [vecSize*dataSize-1:0] wdata_q, rdata_q, merged, loaded;
    logic [vecSize-1:0]          mask_q;
    logic [tagSize-1:0]          tag_q;
    logic                        st_q, err_q, acc, misal, full;
    assign req_ready     = state == IDLE;
    assign acc           = req_valid & req_ready;
    assign misal         = req_addr[1:0] != 2'b00;
    assign full          = &mask_q;
    assign resp_valid    = state == RESP;
    assign resp_rdata    = rdata_q;
    assign resp_tag      = tag_q;
    assign resp_is_store = st_q;
    assign resp_err      = err_q;
    assign mem_addr      = addr_q;
    // wdata_q is overwritten with the merged vector in CAPT, so it always holds what gets written
    assign mem_wdata     = wdata_q;
    // gated by rst so an abandoned read-modify-write can never reach the memory
    assign mem_we        = rst & ((state == ISSUE & st_q & full) | state == WRITE);
    always_comb begin
        merged = '0;
        loaded = '0;
        for (int i = 0; i < vecSize; i++) begin
            merged[i*dataSize +: dataSize] = mask_q[i] ? wdata_q[i*dataSize +: dataSize] : mem_rdata[i*dataSize +: dataSize];
            loaded[i*dataSize +: dataSize] = mask_q[i] ? mem_rdata[i*dataSize +: dataSize] : '0;
        end
    end
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  nxt = !acc ? IDLE : (misal || (req_is_store && req_lane_mask == '0)) ? RESP : ISSUE;
            ISSUE: nxt = (st_q && full) ? RESP : CAPT;
            CAPT:  nxt = st_q ? WRITE : RESP;
            WRITE: nxt = RESP;
            RESP:  nxt = resp_ready ? IDLE : RESP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        state <= !rst ? IDLE : nxt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mask_q  <= '0;
            tag_q   <= '0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (acc) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mask_q  <= req_lane_mask;
                tag_q   <= req_tag;
                st_q    <= req_is_store;
                err_q   <= misal;
                rdata_q <= '0;
            end
            if (state == CAPT) begin
                if (st_q) wdata_q <= merged;
                else rdata_q <= loaded;
            end
        end
    end
endmodule

// File: tb/tb_vector_mem_access_unit.sv
// tb_vector_mem_access_unit: directed self-checking bench for vector_mem_access_unit.
module tb_vector_mem_access_unit;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   req_lane_mask = '0;
    logic [4:0]   req_tag = '0;
    logic         resp_valid, resp_ready = 1'b0, resp_is_store, resp_err;
    logic [127:0] resp_rdata;
    logic [4:0]   resp_tag;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [127:0] mem [0:255];
    logic         pl_en = 1'b0;
    logic [7:0]   pl_idx = '0;
    logic [127:0] pl_dat = '0;
    int pass_n = 0, total = 0;

    vector_mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_lane_mask(req_lane_mask), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_tag(resp_tag), .resp_is_store(resp_is_store), .resp_err(resp_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:2]];
    end

    function automatic logic [127:0] pk(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic preload(input logic [7:0] idx, input logic [127:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Drives one request and records what is seen each cycle until the response appears.
    task automatic run_req(input logic st, input logic [31:0] a, input logic [127:0] wd,
                           input logic [3:0] m, input logic [4:0] t, input logic hs,
                           output int lat, output int we_n, output int we_cyc,
                           output logic [127:0] we_data, output logic [31:0] we_addr,
                           output logic [127:0] rd, output logic [4:0] rt,
                           output logic rs, output logic re);
        lat = -1; we_n = 0; we_cyc = -1; we_data = '0; we_addr = '0;
        rd = 'x; rt = 'x; rs = 1'bx; re = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = wd;
        req_lane_mask = m; req_tag = t; resp_ready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_we) begin
                we_n++; we_cyc = k; we_data = mem_wdata; we_addr = mem_addr;
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; rt = resp_tag; rs = resp_is_store; re = resp_err;
                break;
            end
        end
        if (hs && lat > 0) begin
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
        end
    endtask

    int lat, we_n, we_cyc;
    logic [127:0] we_data, rd;
    logic [31:0] we_addr;
    logic [4:0] rt;
    logic rs, re;

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else pass_n++;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass_n++;
        total++; if (resp_rdata !== 128'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else pass_n++;
        total++; if (resp_tag !== 5'd0) $display("FAIL reset_tag: got %0d want 0", resp_tag); else pass_n++;
        total++; if ({resp_is_store, resp_err} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {resp_is_store, resp_err}); else pass_n++;
        total++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else pass_n++;
        total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_n++;
        total++; if (mem_wdata !== 128'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else pass_n++;
        rst = 1'b1;
    endtask

    task automatic test_load;
        preload(8'd16, pk(11, 22, 33, 44));
        run_req(1'b0, 32'h40, pk(99, 99, 99, 99), 4'b1111, 5'd7, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 3) $display("FAIL load_latency: got %0d want 3", lat); else pass_n++;
        total++; if (rd !== pk(11, 22, 33, 44)) $display("FAIL load_rdata: got %h want %h", rd, pk(11, 22, 33, 44)); else pass_n++;
        total++; if (rt !== 5'd7) $display("FAIL load_tag: got %0d want 7", rt); else pass_n++;
        total++; if ({rs, re} !== 2'b00) $display("FAIL load_flags: got %b want 00", {rs, re}); else pass_n++;
        total++; if (we_n !== 0) $display("FAIL load_no_we: got %0d pulses want 0", we_n); else pass_n++;
        run_req(1'b0, 32'h40, '0, 4'b0110, 5'd3, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 3) $display("FAIL load_mask_latency: got %0d want 3", lat); else pass_n++;
        total++; if (rd !== pk(0, 22, 33, 0)) $display("FAIL load_mask_rdata: got %h want %h", rd, pk(0, 22, 33, 0)); else pass_n++;
        total++; if (rt !== 5'd3) $display("FAIL load_mask_tag: got %0d want 3", rt); else pass_n++;
    endtask

    task automatic test_full_store;
        run_req(1'b1, 32'h80, pk(32'hA, 32'hB, 32'hC, 32'hD), 4'b1111, 5'd9, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 2) $display("FAIL fstore_latency: got %0d want 2", lat); else pass_n++;
        total++; if (we_n !== 1) $display("FAIL fstore_we_count: got %0d want 1", we_n); else pass_n++;
        total++; if (we_cyc !== 1) $display("FAIL fstore_we_cycle: got %0d want 1", we_cyc); else pass_n++;
        total++; if (we_data !== pk(32'hA, 32'hB, 32'hC, 32'hD)) $display("FAIL fstore_wdata: got %h want %h", we_data, pk(32'hA, 32'hB, 32'hC, 32'hD)); else pass_n++;
        total++; if (we_addr !== 32'h80) $display("FAIL fstore_addr: got %h want 80", we_addr); else pass_n++;
        total++; if ({rs, re, rt} !== {2'b10, 5'd9}) $display("FAIL fstore_resp: got st=%b err=%b tag=%0d want 1 0 9", rs, re, rt); else pass_n++;
        total++; if (rd !== 128'h0) $display("FAIL fstore_rdata: got %h want 0", rd); else pass_n++;
        run_req(1'b0, 32'h80, '0, 4'b1111, 5'd1, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (rd !== pk(32'hA, 32'hB, 32'hC, 32'hD)) $display("FAIL fstore_readback: got %h want %h", rd, pk(32'hA, 32'hB, 32'hC, 32'hD)); else pass_n++;
    endtask

    task automatic test_partial_store;
        run_req(1'b1, 32'h80, pk(1, 2, 3, 4), 4'b0101, 5'd4, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 4) $display("FAIL pstore_latency: got %0d want 4", lat); else pass_n++;
        total++; if (we_n !== 1) $display("FAIL pstore_we_count: got %0d want 1", we_n); else pass_n++;
        total++; if (we_cyc !== 3) $display("FAIL pstore_we_cycle: got %0d want 3", we_cyc); else pass_n++;
        total++; if (we_data !== pk(1, 32'hB, 3, 32'hD)) $display("FAIL pstore_merged: got %h want %h", we_data, pk(1, 32'hB, 3, 32'hD)); else pass_n++;
        total++; if (we_addr !== 32'h80) $display("FAIL pstore_addr: got %h want 80", we_addr); else pass_n++;
        total++; if ({rs, re, rt, rd} !== {2'b10, 5'd4, 128'h0}) $display("FAIL pstore_resp: got st=%b err=%b tag=%0d rdata=%h want 1 0 4 0", rs, re, rt, rd); else pass_n++;
        run_req(1'b0, 32'h80, '0, 4'b1111, 5'd2, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (rd !== pk(1, 32'hB, 3, 32'hD)) $display("FAIL pstore_readback: got %h want %h", rd, pk(1, 32'hB, 3, 32'hD)); else pass_n++;
    endtask

    task automatic test_short_paths;
        run_req(1'b1, 32'h80, pk(7, 7, 7, 7), 4'b0000, 5'd5, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 1) $display("FAIL zmask_latency: got %0d want 1", lat); else pass_n++;
        total++; if (we_n !== 0) $display("FAIL zmask_no_we: got %0d want 0", we_n); else pass_n++;
        total++; if ({rs, re, rt} !== {2'b10, 5'd5}) $display("FAIL zmask_resp: got st=%b err=%b tag=%0d want 1 0 5", rs, re, rt); else pass_n++;
        run_req(1'b0, 32'h42, '0, 4'b1111, 5'd6, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 1) $display("FAIL misload_latency: got %0d want 1", lat); else pass_n++;
        total++; if (re !== 1'b1) $display("FAIL misload_err: got %b want 1", re); else pass_n++;
        total++; if (rd !== 128'h0) $display("FAIL misload_rdata: got %h want 0", rd); else pass_n++;
        total++; if ({rs, rt} !== {1'b0, 5'd6}) $display("FAIL misload_resp: got st=%b tag=%0d want 0 6", rs, rt); else pass_n++;
        run_req(1'b1, 32'h86, pk(5, 5, 5, 5), 4'b1111, 5'd8, 1'b1, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 1) $display("FAIL misstore_latency: got %0d want 1", lat); else pass_n++;
        total++; if ({we_n, re} !== {32'd0, 1'b1}) $display("FAIL misstore: got we=%0d err=%b want 0 1", we_n, re); else pass_n++;
        total++; if (mem[32] !== pk(1, 32'hB, 3, 32'hD)) $display("FAIL short_mem_intact: got %h want %h", mem[32], pk(1, 32'hB, 3, 32'hD)); else pass_n++;
    endtask

    task automatic test_stall;
        run_req(1'b0, 32'h40, '0, 4'b1111, 5'd12, 1'b0, lat, we_n, we_cyc, we_data, we_addr, rd, rt, rs, re);
        total++; if (lat !== 3) $display("FAIL stall_latency: got %0d want 3", lat); else pass_n++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b1 || resp_rdata !== pk(11, 22, 33, 44) || resp_tag !== 5'd12 || resp_err !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL stall_hold_%0d: got v=%b rdata=%h tag=%0d err=%b rdy=%b want 1 %h 12 0 0", c, resp_valid, resp_rdata, resp_tag, resp_err, req_ready, pk(11, 22, 33, 44));
            else pass_n++;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        total++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL stall_release: got rdy=%b v=%b want 1 0", req_ready, resp_valid); else pass_n++;
    endtask

    task automatic test_reset_mid;
        int we_seen;
        we_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_addr = 32'h80;
        req_wdata = pk(5, 6, 7, 8); req_lane_mask = 4'b0011; req_tag = 5'd13;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (k == 2) rst = 1'b0;
            if (k == 5) rst = 1'b1;
            if (mem_we) we_seen++;
        end
        total++; if (we_seen !== 0) $display("FAIL rstmid_no_we: got %0d pulses want 0", we_seen); else pass_n++;
        total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready); else pass_n++;
        total++;
        if ({resp_valid, resp_is_store, resp_err, mem_we} !== 4'b0 || resp_rdata !== '0 || resp_tag !== '0 || mem_addr !== '0 || mem_wdata !== '0)
            $display("FAIL rstmid_outputs: got v=%b st=%b err=%b we=%b rdata=%h tag=%0d addr=%h wdata=%h want all 0", resp_valid, resp_is_store, resp_err, mem_we, resp_rdata, resp_tag, mem_addr, mem_wdata);
        else pass_n++;
        total++; if (mem[32] !== pk(1, 32'hB, 3, 32'hD)) $display("FAIL rstmid_mem: got %h want %h", mem[32], pk(1, 32'hB, 3, 32'hD)); else pass_n++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_short_paths();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end
endmodule

// File: doc/vector_mem_access_unit.md
Name: vector_mem_access_unit

Overview:
- Memory-stage controller between the execute stage and the vector data memory.
- Accepts one vector load or store per request over a valid/ready handshake and drives the data memory port.
- The data memory port has a 1-cycle registered read and whole-vector writes, so the unit performs read-modify-write for lane-masked stores.
- Returns load data, or store completion, to writeback over a valid/ready handshake.

Parameters:
dataSize, 32, bits per vector lane
addressingSize, 32, address width
vecSize, 4, lanes per vector
tagSize, 5, width of the destination/ID tag carried with each request

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_is_store  input  1  1 = store, 0 = load
req_addr  input  addressingSize  byte address of lane 0
req_wdata  input  vecSize x dataSize  store data, lane i = req_wdata[i]
req_lane_mask  input  vecSize  bit i enables lane i
req_tag  input  tagSize  opaque ID, returned unchanged
resp_valid  output  1  response present
resp_ready  input  1  writeback accepts response
resp_rdata  output  vecSize x dataSize  load result; 0 for stores
resp_tag  output  tagSize  tag of the completed request
resp_is_store  output  1  completed request was a store
resp_err  output  1  request was rejected as misaligned
mem_we  output  1  data memory write enable
mem_addr  output  addressingSize  data memory address
mem_wdata  output  vecSize x dataSize  data memory write data
mem_rdata  input  vecSize x dataSize  data memory read data, valid 1 cycle after the address is presented with mem_we=0

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; resp_valid, resp_rdata, resp_tag, resp_is_store, resp_err = 0.
  - Address and data registers are cleared, so mem_addr = 0 and mem_wdata = 0.
  - mem_we is gated combinationally by rst and is 0 whenever rst=0, including mid-operation. An in-flight RMW is abandoned with no write.
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready. On accept, latch addr, wdata, mask, tag and is_store.
- States: IDLE, ISSUE, CAPT, WRITE, RESP.
- From IDLE on accept:
  - If addr[1:0] != 0: go to RESP with resp_err=1 and no memory access.
  - Else, store with mask = 0: go to RESP with no memory access.
  - Else: go to ISSUE.
- ISSUE: mem_addr = latched addr.
  - Store with mask all ones: mem_we=1, mem_wdata = latched wdata; next state RESP.
  - Otherwise (load or partial store): mem_we=0; next state CAPT.
- CAPT: sample mem_rdata.
  - Load: resp_rdata[i] = mask[i] ? mem_rdata[i] : 0; next state RESP.
  - Partial store: merged[i] = mask[i] ? wdata[i] : mem_rdata[i]; next state WRITE.
- WRITE: mem_addr = latched addr, mem_we=1, mem_wdata = merged; next state RESP.
- RESP:
  - resp_valid=1; all resp_* fields stable until resp_ready.
  - resp_ready=1: go to IDLE and clear resp_valid.
  - resp_ready=0: hold.
  - No same-cycle accept.
- mem_we=0 in every state other than ISSUE (full store) and WRITE.
- mem_addr is passed through unmodified.
- Latency, accept at cycle T to resp_valid:
  - load: T+3
  - full-mask store: T+2
  - partial store: T+4
  - zero-mask store or misaligned: T+1
- resp_err=1 implies resp_rdata=0 and no mem_we pulse for that request.
- Loads ignore req_wdata. resp_rdata=0 for all stores.

Test Plan:
1. Memory word at 0x40 = {11,22,33,44}; load addr 0x40, mask 1111, tag 7 -> resp_valid at T+3, rdata {11,22,33,44}, tag 7, err 0; mem_we never asserted.
2. Store {A,B,C,D} to 0x80, mask 1111 -> exactly one mem_we pulse at T+1 with wdata {A,B,C,D}; resp at T+2; a following load of 0x80 returns {A,B,C,D}.
3. Memory at 0x80 = {A,B,C,D}; store {1,2,3,4}, mask 0101 -> mem_we=0 at T+1, mem_we=1 at T+3 with wdata {1,B,3,D} (lane 0 = mask bit 0); resp at T+4.
4. Store with mask 0000, and load addr 0x42 -> resp at T+1; no mem_we; misaligned case gives err=1 and rdata 0.
5. Load completes with resp_ready held 0 for 5 cycles -> resp fields stable, req_ready=0 throughout; one cycle after resp_ready=1 handshake, req_ready=1.
6. Partial store, rst driven 0 during CAPT -> no mem_we pulse ever; after release, state IDLE, all outputs 0, req_ready=1; memory unchanged.
